// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - two-master round-robin APB arbiter with access-phase timeout
module apb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          APB_PCLK,
  input  logic          APB_PRESETn,
  input  logic          m0_psel,
  input  logic          m0_pwrite,
  input  logic [AW-1:0] m0_paddr,
  input  logic [DW-1:0] m0_pwdata,
  output logic [DW-1:0] m0_prdata,
  output logic          m0_pready,
  output logic          m0_perr,
  input  logic          m1_psel,
  input  logic          m1_pwrite,
  input  logic [AW-1:0] m1_paddr,
  input  logic [DW-1:0] m1_pwdata,
  output logic [DW-1:0] m1_prdata,
  output logic          m1_pready,
  output logic          m1_perr,
  output logic          s_psel,
  output logic          s_penable,
  output logic          s_pwrite,
  output logic [AW-1:0] s_paddr,
  output logic [DW-1:0] s_pwdata,
  input  logic [DW-1:0] s_prdata,
  input  logic          s_pready,
  input  logic          s_perr,
  output logic          grant,
  output logic          busy
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_grant;
  logic          r_pwrite;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic [CW-1:0] r_cnt;

  logic          w_req;
  logic          w_pick;
  logic          w_timeout;
  logic          w_end;
  logic          w_done;
  logic [DW-1:0] w_rdata;
  logic          w_err;

  // On a tie the master that did not own the last transfer wins
  assign w_req     = m0_psel | m1_psel;
  assign w_pick    = (m0_psel && m1_psel) ? ~r_grant : ~m0_psel;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == LAST) && !s_pready;
  assign w_end     = (r_state == ACCESS) && (s_pready || w_timeout);
  // A reset arriving during the completing cycle suppresses the strobe
  assign w_done    = w_end && APB_PRESETn;
  assign w_rdata   = (s_pready && !r_pwrite) ? s_prdata : '0;
  assign w_err     = s_pready ? s_perr : 1'b1;

  always_ff @(posedge APB_PCLK) begin
    if (!APB_PRESETn) r_state <= IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (w_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge APB_PCLK) begin
    if (!APB_PRESETn) begin
      r_grant  <= 1'b1;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_cnt    <= '0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_grant  <= w_pick;
        r_pwrite <= w_pick ? m1_pwrite : m0_pwrite;
        r_paddr  <= w_pick ? m1_paddr  : m0_paddr;
        r_pwdata <= w_pick ? m1_pwdata : m0_pwdata;
      end
      // Saturates so a disabled timeout with a hung slave never wraps
      if (r_state == ACCESS && !w_end) begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    s_psel    = (r_state != IDLE);
    s_penable = (r_state == ACCESS);
    busy      = (r_state != IDLE);
    m0_pready = 1'b0;
    m0_perr   = 1'b0;
    m0_prdata = '0;
    m1_pready = 1'b0;
    m1_perr   = 1'b0;
    m1_prdata = '0;
    if (w_done) begin
      if (r_grant) begin
        m1_pready = 1'b1;
        m1_perr   = w_err;
        m1_prdata = w_rdata;
      end else begin
        m0_pready = 1'b1;
        m0_perr   = w_err;
        m0_prdata = w_rdata;
      end
    end
  end

  assign s_pwrite = r_pwrite;
  assign s_paddr  = r_paddr;
  assign s_pwdata = r_pwdata;
  assign grant    = r_grant;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - scoreboard bench for apb_arbiter with a scripted slave
module tb_apb_arbiter;
  logic        clk;
  logic        resetn;
  logic        m0_pwrite, m1_pwrite;
  logic [31:0] m0_paddr, m1_paddr, m0_pwdata, m1_pwdata;
  logic [31:0] m0_prdata, m1_prdata;
  logic        m0_pready, m1_pready, m0_perr, m1_perr;
  logic        s_psel, s_penable, s_pwrite;
  logic [31:0] s_paddr, s_pwdata;
  logic [31:0] sl_data;
  logic        s_pready, s_perr;
  logic        grant, busy;

  logic        sl_hang, sl_err;
  int          sl_wait, acc;

  int m0_issued, m0_done, m0_drop;
  int m1_issued, m1_done, m1_drop;
  wire m0_psel = (m0_issued != m0_done + m0_drop);
  wire m1_psel = (m1_issued != m1_done + m1_drop);

  int errors, checks;

  typedef struct {
    logic        m;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
  } exp_t;
  exp_t q[$];

  apb_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .APB_PCLK(clk), .APB_PRESETn(resetn),
    .m0_psel(m0_psel), .m0_pwrite(m0_pwrite), .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata),
    .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_perr(m0_perr),
    .m1_psel(m1_psel), .m1_pwrite(m1_pwrite), .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata),
    .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_perr(m1_perr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(sl_data),
    .s_pready(s_pready), .s_perr(s_perr),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave: ready after sl_wait wait states unless hung
  always @(posedge clk) begin
    #1;
    if (s_psel && s_penable) acc = acc + 1;
    else acc = 0;
    s_pready = s_psel && s_penable && !sl_hang && (acc == sl_wait + 1);
    s_perr   = s_pready && sl_err;
  end

  // Scoreboard monitor; also retires the master request that completed
  always @(negedge clk) begin
    if (m0_pready || m1_pready) begin
      if (m0_pready && m1_pready) begin
        checks++; errors++;
        $display("FAIL both_pready: m0_pready=%b m1_pready=%b, required at most one", m0_pready, m1_pready);
      end else if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pready: m0_pready=%b m1_pready=%b with nothing outstanding", m0_pready, m1_pready);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_master", {31'b0, m1_pready}, {31'b0, e.m});
        chk("sb_grant", {31'b0, grant}, {31'b0, e.m});
        chk("sb_rdata", m1_pready ? m1_prdata : m0_prdata, e.rdata);
        chk("sb_perr", {31'b0, m1_pready ? m1_perr : m0_perr}, {31'b0, e.err});
        chk("sb_addr", s_paddr, e.addr);
        chk("sb_other_quiet", m1_pready ? {m0_prdata[30:0], m0_perr} : {m1_prdata[30:0], m1_perr}, 32'h0);
      end
      if (m0_pready) m0_done++;
      if (m1_pready) m1_done++;
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    @(posedge clk); #1;
    while ((q.size() != 0 || busy) && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= max_cycles) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d expectations outstanding, busy=%b", q.size(), busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    errors = 0; checks = 0;
    m0_issued = 0; m0_done = 0; m0_drop = 0;
    m1_issued = 0; m1_done = 0; m1_drop = 0;
    m0_pwrite = 0; m0_paddr = 0; m0_pwdata = 0;
    m1_pwrite = 0; m1_paddr = 0; m1_pwdata = 0;
    sl_data = 0; sl_hang = 0; sl_err = 0; sl_wait = 0; acc = 0;
    s_pready = 0; s_perr = 0;
    do_reset();

    @(negedge clk);
    chk("rst_psel", {31'b0, s_psel}, 32'h0);
    chk("rst_penable", {31'b0, s_penable}, 32'h0);
    chk("rst_grant", {31'b0, grant}, 32'h1);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_paddr", s_paddr, 32'h0);

    // Single zero-wait read from master 0
    @(posedge clk); #1;
    sl_data = 32'hDEADBEEF;
    m0_pwrite = 0; m0_paddr = 32'h100;
    q.push_back('{1'b0, 32'hDEADBEEF, 1'b0, 32'h100});
    m0_issued++;
    @(negedge clk);
    chk("t1_idle_psel", {31'b0, s_psel}, 32'h0);
    @(negedge clk);
    chk("t1_setup_psel", {31'b0, s_psel}, 32'h1);
    chk("t1_setup_penable", {31'b0, s_penable}, 32'h0);
    @(negedge clk);
    chk("t1_access_penable", {31'b0, s_penable}, 32'h1);
    chk("t1_m0_pready", {31'b0, m0_pready}, 32'h1);
    chk("t1_m0_prdata", m0_prdata, 32'hDEADBEEF);
    chk("t1_m1_pready", {31'b0, m1_pready}, 32'h0);
    wait_drain(50);

    // Simultaneous writes right after reset: master 0 first
    do_reset();
    sl_data = 32'h11112222;
    m0_pwrite = 1; m0_paddr = 32'h10; m0_pwdata = 32'hA0;
    m1_pwrite = 1; m1_paddr = 32'h20; m1_pwdata = 32'hB0;
    q.push_back('{1'b0, 32'h0, 1'b0, 32'h10});
    q.push_back('{1'b1, 32'h0, 1'b0, 32'h20});
    m0_issued++; m1_issued++;
    repeat (2) @(negedge clk);
    chk("t2_first_paddr", s_paddr, 32'h10);
    chk("t2_first_pwdata", s_pwdata, 32'hA0);
    chk("t2_first_grant", {31'b0, grant}, 32'h0);
    repeat (2) @(negedge clk);
    chk("t2_turnaround_psel", {31'b0, s_psel}, 32'h0);
    @(negedge clk);
    chk("t2_second_paddr", s_paddr, 32'h20);
    chk("t2_second_pwdata", s_pwdata, 32'hB0);
    chk("t2_second_grant", {31'b0, grant}, 32'h1);
    wait_drain(50);

    // Fairness: both request three transfers each
    @(posedge clk); #1;
    sl_data = 32'h12345678;
    m0_pwrite = 0; m0_paddr = 32'h30;
    m1_pwrite = 0; m1_paddr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      q.push_back('{1'b0, 32'h12345678, 1'b0, 32'h30});
      q.push_back('{1'b1, 32'h12345678, 1'b0, 32'h40});
    end
    m0_issued += 3; m1_issued += 3;
    wait_drain(100);

    // Three wait states then an error response to master 1
    @(posedge clk); #1;
    sl_data = 32'hCAFE0001; sl_wait = 3; sl_err = 1;
    m1_pwrite = 0; m1_paddr = 32'h44;
    q.push_back('{1'b1, 32'hCAFE0001, 1'b1, 32'h44});
    m1_issued++;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_wait_penable", {31'b0, s_penable}, 32'h1);
      chk("t4_wait_pready", {31'b0, m1_pready}, 32'h0);
      chk("t4_wait_paddr", s_paddr, 32'h44);
    end
    @(negedge clk);
    chk("t4_m1_pready", {31'b0, m1_pready}, 32'h1);
    chk("t4_m1_perr", {31'b0, m1_perr}, 32'h1);
    chk("t4_final_paddr", s_paddr, 32'h44);
    wait_drain(50);

    // Hung slave: timeout on the 4th access cycle, then m1 proceeds
    @(posedge clk); #1;
    sl_data = 32'h55AA55AA; sl_wait = 0; sl_err = 0; sl_hang = 1;
    m0_pwrite = 0; m0_paddr = 32'h50;
    q.push_back('{1'b0, 32'h0, 1'b1, 32'h50});
    m0_issued++;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_wait_pready", {31'b0, m0_pready}, 32'h0);
    end
    @(negedge clk);
    chk("t5_to_pready", {31'b0, m0_pready}, 32'h1);
    chk("t5_to_perr", {31'b0, m0_perr}, 32'h1);
    chk("t5_to_prdata", m0_prdata, 32'h0);
    @(negedge clk);
    chk("t5_abort_psel", {31'b0, s_psel}, 32'h0);
    @(posedge clk); #1;
    sl_hang = 0;
    m1_pwrite = 0; m1_paddr = 32'h60;
    q.push_back('{1'b1, 32'h55AA55AA, 1'b0, 32'h60});
    m1_issued++;
    wait_drain(50);

    // Reset during access abandons the transfer silently
    @(posedge clk); #1;
    sl_hang = 1;
    m0_pwrite = 0; m0_paddr = 32'h70;
    m0_issued++;
    repeat (3) @(negedge clk);
    chk("t6_in_access", {31'b0, s_penable}, 32'h1);
    @(posedge clk); #1;
    resetn = 1'b0;
    m0_drop++;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_psel", {31'b0, s_psel}, 32'h0);
    chk("t6_penable", {31'b0, s_penable}, 32'h0);
    chk("t6_busy", {31'b0, busy}, 32'h0);
    chk("t6_grant", {31'b0, grant}, 32'h1);
    chk("t6_m0_pready", {31'b0, m0_pready}, 32'h0);
    repeat (5) @(negedge clk);
    sl_hang = 0;
    wait_drain(20);
    chk("final_queue_empty", q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
